banked_ram_dp: RTL and testbench

//  Simple dual-port synchronous RAM: one write port, one read port, both on the same clock.

---
 rtl/banked_ram_dp_pkg.sv | 13 +
 rtl/banked_ram_dp_ram_lane.sv | 23 ++
 rtl/banked_ram_dp.sv | 114 +++++++++++
 tb/tb_banked_ram_dp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/banked_ram_dp_pkg.sv
// rtl/banked_ram_dp_pkg.sv - shared FSM encoding and lane-count helper for banked RAMs
package banked_ram_dp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int lane_count(input int width, input int lane_width);
    return width / lane_width;
  endfunction

endpackage

// File: rtl/banked_ram_dp_ram_lane.sv
// rtl/banked_ram_dp_ram_lane.sv - one lane-wide storage array with its own write enable
module ram_lane #(
  parameter int LaneWidth   = 8,
  parameter int AddressSize = 4
) (
  input  logic                   clk,
  input  logic                   wen,
  input  logic [AddressSize-1:0] waddr,
  input  logic [LaneWidth-1:0]   wdata,
  input  logic [AddressSize-1:0] raddr,
  output logic [LaneWidth-1:0]   rdata
);

  logic [LaneWidth-1:0] mem [2**AddressSize];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  // Unregistered read of the pre-edge contents; the top registers it.
  assign rdata = mem[raddr];

endmodule

// File: rtl/banked_ram_dp.sv
// rtl/banked_ram_dp.sv - dual-port lane-enabled RAM with clear engine and 1/2-cycle read pipeline
module banked_ram_dp
  import banked_ram_dp_pkg::*;
#(
  parameter int Width        = 8,
  parameter int LaneWidth    = 8,
  parameter int AddressSize  = 4,
  parameter int ReadLatency  = 1,
  parameter int ClearOnReset = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [Width/LaneWidth-1:0]   be,
  input  logic [AddressSize-1:0]       waddr,
  input  logic [Width-1:0]             D,
  input  logic                         re,
  input  logic [AddressSize-1:0]       raddr,
  output logic [Width-1:0]             Q,
  output logic                         valid,
  output logic                         busy
);

  localparam int Lanes = lane_count(Width, LaneWidth);
  localparam logic [AddressSize-1:0] LastAddr = '1;

  if (Lanes * LaneWidth != Width) begin : g_bad_width
    $error("banked_ram_dp: Width must be a multiple of LaneWidth");
  end
  if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
    $error("banked_ram_dp: ReadLatency must be 1 or 2");
  end

  state_t                 state;
  logic [AddressSize-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (ClearOnReset != 0) ? ST_CLEAR : ST_READY;
      busy  <= (ClearOnReset != 0);
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == LastAddr) begin
        state <= ST_READY;
        busy  <= 1'b0;
      end
    end
  end

  logic                   clearing, ready, rd_accept;
  logic [AddressSize-1:0] lane_waddr;
  logic [Width-1:0]       rd_word;

  assign clearing   = (state == ST_CLEAR) && !rst;
  assign ready      = (state == ST_READY) && !rst;
  assign rd_accept  = ready && re;
  assign lane_waddr = clearing ? ptr : waddr;

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    logic [LaneWidth-1:0] lane_rd;
    logic [LaneWidth-1:0] lane_wd;
    logic                 lane_we;

    assign lane_we = clearing || (ready && we && be[i]);
    assign lane_wd = clearing ? '0 : D[i*LaneWidth +: LaneWidth];

    ram_lane #(
      .LaneWidth  (LaneWidth),
      .AddressSize(AddressSize)
    ) u_lane (
      .clk  (clk),
      .wen  (lane_we),
      .waddr(lane_waddr),
      .wdata(lane_wd),
      .raddr(raddr),
      .rdata(lane_rd)
    );

    // Write-first per lane on a same-address collision.
    assign rd_word[i*LaneWidth +: LaneWidth] =
      (we && be[i] && (waddr == raddr)) ? D[i*LaneWidth +: LaneWidth] : lane_rd;
  end

  if (ReadLatency == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        Q     <= '0;
        valid <= 1'b0;
      end else begin
        valid <= rd_accept;
        if (rd_accept) Q <= rd_word;
      end
    end
  end else begin : g_lat2
    logic             s1_valid;
    logic [Width-1:0] s1_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        Q        <= '0;
        valid    <= 1'b0;
        s1_valid <= 1'b0;
        s1_data  <= '0;
      end else begin
        s1_valid <= rd_accept;
        if (rd_accept) s1_data <= rd_word;
        valid <= s1_valid;
        if (s1_valid) Q <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_banked_ram_dp.sv
// tb/tb_banked_ram_dp.sv - directed plus random checks of banked_ram_dp against a behavioural model
module tb_banked_ram_dp;

  localparam int W     = 16;
  localparam int LW    = 8;
  localparam int AS    = 4;
  localparam int L     = W / LW;
  localparam int DEPTH = 2**AS;

  logic          clk = 1'b0;
  logic          rst, we, re;
  logic [L-1:0]  be;
  logic [AS-1:0] waddr, raddr;
  logic [W-1:0]  D, Q, Q2;
  logic          valid, valid2, busy, busy2;

  always #5 clk = ~clk;

  banked_ram_dp #(.Width(W), .LaneWidth(LW), .AddressSize(AS), .ReadLatency(1), .ClearOnReset(1)) dut (
    .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .D(D),
    .re(re), .raddr(raddr), .Q(Q), .valid(valid), .busy(busy)
  );

  banked_ram_dp #(.Width(W), .LaneWidth(LW), .AddressSize(AS), .ReadLatency(2), .ClearOnReset(1)) dut2 (
    .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .D(D),
    .re(re), .raddr(raddr), .Q(Q2), .valid(valid2), .busy(busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: word array, count of words still to clear, expected outputs.
  logic [W-1:0] mem [DEPTH];
  int           clear_left = 0;
  logic         ev, ev2, pv;
  logic [W-1:0] eq, eq2, pq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] rv;
    if (rst) begin
      clear_left = DEPTH;
      ev = 1'b0; eq = '0; pv = 1'b0; pq = '0; ev2 = 1'b0; eq2 = '0;
    end else begin
      ev2 = pv;
      if (pv) eq2 = pq;
      if (clear_left > 0) begin
        mem[DEPTH - clear_left] = '0;
        clear_left--;
        ev = 1'b0;
        pv = 1'b0;
      end else begin
        rv = mem[raddr];
        for (int i = 0; i < L; i++)
          if (we && be[i] && waddr == raddr) rv[i*LW +: LW] = D[i*LW +: LW];
        for (int i = 0; i < L; i++)
          if (we && be[i]) mem[waddr][i*LW +: LW] = D[i*LW +: LW];
        ev = re;
        pv = re;
        if (re) begin
          eq = rv;
          pq = rv;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy",   32'(busy),   32'(clear_left > 0));
    chk("valid",  32'(valid),  32'(ev));
    chk("q",      32'(Q),      32'(eq));
    chk("busy2",  32'(busy2),  32'(clear_left > 0));
    chk("valid2", 32'(valid2), 32'(ev2));
    chk("q2",     32'(Q2),     32'(eq2));
  endtask

  task automatic drive(input logic w, input logic [AS-1:0] wa, input logic [W-1:0] d,
                       input logic [L-1:0] b, input logic r, input logic [AS-1:0] ra);
    we = w; waddr = wa; D = d; be = b; re = r; raddr = ra;
  endtask

  int busy_edges;
  logic [5:0] vpat, vpat2;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // 1: reset, clear for 16 edges, then every word reads zero
    step();
    chk("t1_busy_after_rst", 32'(busy), 32'd1);
    rst = 1'b0;
    busy_edges = 0;
    while (busy && busy_edges < 40) begin
      step();
      busy_edges++;
    end
    chk("t1_busy_edges", busy_edges, 16);
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, 0, 0, 1, AS'(a));
      step();
      chk("t1_q_zero", 32'(Q), 32'h0);
      chk("t1_valid", 32'(valid), 32'd1);
    end

    // 2: full write then read back, valid is a single pulse
    drive(1, 3, 16'hA55A, 2'b11, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 3);
    step();
    chk("t2_q", 32'(Q), 32'hA55A);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t2_valid_drop", 32'(valid), 32'd0);

    // 3: lower-lane only write
    drive(1, 3, 16'h1234, 2'b01, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 3);
    step();
    chk("t3_q", 32'(Q), 32'hA534);

    // 4: same-edge collision, write-first per lane
    drive(1, 5, 16'hBEEF, 2'b10, 1, 5);
    step();
    chk("t4_q_upper", 32'(Q), 32'hBE00);
    drive(1, 5, 16'hBEEF, 2'b11, 1, 5);
    step();
    chk("t4_q_full", 32'(Q), 32'hBEEF);

    // 5: requests during busy are ignored
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 2, 16'hFFFF, 2'b11, 1, 2);
    for (int c = 0; c < DEPTH; c++) begin
      step();
      chk("t5_valid_busy", 32'(valid), 32'd0);
    end
    drive(0, 0, 0, 0, 1, 2);
    step();
    chk("t5_q", 32'(Q), 32'h0000);

    // 6: reset on clear edge 7 restarts the full clear
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_edges = 0;
    while (busy && busy_edges < 40) begin
      step();
      busy_edges++;
    end
    chk("t6_busy_edges", busy_edges, 16);

    // 6: four streamed reads, both latencies
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(0, 0, 0, 0, 1, AS'(c));
      else drive(0, 0, 0, 0, 0, 0);
      step();
      vpat[c]  = valid;
      vpat2[c] = valid2;
    end
    chk("t6_stream_lat1", 32'(vpat), 32'b001111);
    chk("t6_stream_lat2", 32'(vpat2), 32'b011110);

    // Random traffic with occasional reset
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom), AS'($urandom), W'($urandom), L'($urandom),
            1'($urandom), AS'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
